// File: rtl/pc_register.sv
// Program-counter stage: registers next_pc and sequences BOOT/RUN/HALT/FAULT.
// Optional PC_TRACE_EN adds a retired_count output counting PC loads.
module pc_register #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             fault,
`ifdef PC_TRACE_EN
    output logic [31:0]      retired_count,
`endif
    output logic [1:0]       state
);

    localparam logic [1:0] S_BOOT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_HALT  = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    logic [1:0] st, st_nxt;
    logic       load;

    // RUN priority: halt, then stall, then misalignment, then load
    always_comb begin
        st_nxt = st;
        load   = 1'b0;
        case (st)
            S_BOOT: st_nxt = S_RUN;
            S_RUN: begin
                if (halt)                      st_nxt = S_HALT;
                else if (stall)                st_nxt = S_RUN;
                else if (next_pc[1:0] != 2'b00) st_nxt = S_FAULT;
                else                           load   = 1'b1;
            end
            S_HALT:  if (resume) st_nxt = S_RUN;
            default: st_nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_BOOT;
            pc <= RESET_PC;
        end else begin
            st <= st_nxt;
            if (load) pc <= next_pc;
        end
    end

`ifdef PC_TRACE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       retired_count <= '0;
        else if (load) retired_count <= retired_count + 32'd1;
    end
`endif

    assign pc_plus4    = pc + WIDTH'(4);
    assign state       = st;
    assign fetch_valid = (st == S_RUN);
    assign fault       = (st == S_FAULT);

endmodule

// File: tb/tb_pc_register.sv
// Directed bench for pc_register: boot, run, stall, halt/resume, fault, wrap.
module tb_pc_register;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        stall, halt, resume;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, fault;
    logic [1:0]  state;
`ifdef PC_TRACE_EN
    logic [31:0] retired_count;
`endif

    int total = 0;
    int bad   = 0;

    pc_register #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .stall(stall), .halt(halt),
        .resume(resume), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .fault(fault),
`ifdef PC_TRACE_EN
        .retired_count(retired_count),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_retired(input string tag, input logic [31:0] exp);
`ifdef PC_TRACE_EN
        chk(tag, retired_count, exp);
`endif
    endtask

    initial begin
        rst = 1'b1; next_pc = '0; stall = 0; halt = 0; resume = 0;
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_fv", 32'(fetch_valid), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        rst = 1'b0;
        step();
        chk("boot_state", 32'(state), 32'h1);
        chk("boot_fv", 32'(fetch_valid), 32'h1);
        chk("boot_pc", pc, 32'h0);
        chk_retired("boot_ret", 32'd0);

        // sequential fetch
        for (int i = 1; i <= 4; i++) begin
            next_pc = 32'(4 * i);
            step();
            chk("seq_pc", pc, 32'(4 * i));
        end
        chk("seq_plus4", pc_plus4, 32'h14);
        chk_retired("seq_ret", 32'd4);

        // stall holds pc
        stall = 1; next_pc = 32'h40;
        step(); chk("stall1_pc", pc, 32'h10);
        step(); chk("stall2_pc", pc, 32'h10);
        stall = 0;
        step(); chk("unstall_pc", pc, 32'h40);
        chk_retired("stall_ret", 32'd5);

        // halt beats stall; HALT waits for resume
        halt = 1; stall = 1; next_pc = 32'h80;
        step();
        chk("halt_state", 32'(state), 32'h2);
        chk("halt_fv", 32'(fetch_valid), 32'h0);
        chk("halt_pc", pc, 32'h40);
        halt = 0; stall = 0;
        step();
        chk("halt_hold_state", 32'(state), 32'h2);
        halt = 1; resume = 1;
        step();
        chk("resume_state", 32'(state), 32'h1);
        chk("resume_pc", pc, 32'h40);
        chk_retired("halt_ret", 32'd5);

        // misaligned target -> sticky fault
        halt = 0; resume = 0; next_pc = 32'h42;
        step();
        chk("fault_state", 32'(state), 32'h3);
        chk("fault_flag", 32'(fault), 32'h1);
        chk("fault_fv", 32'(fetch_valid), 32'h0);
        chk("fault_pc", pc, 32'h40);
        resume = 1; halt = 1; next_pc = 32'h44;
        step();
        chk("fault_sticky", 32'(state), 32'h3);
        chk("fault_sticky_pc", pc, 32'h40);
        chk_retired("fault_ret", 32'd5);

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_state", 32'(state), 32'h0);
        chk("arst_fault", 32'(fault), 32'h0);
        chk_retired("arst_ret", 32'd0);
        step();
        rst = 0; resume = 0; halt = 0; next_pc = 32'h0;
        step();
        chk("reboot_state", 32'(state), 32'h1);

        // self-loop is a real load
        step();
        chk("self_pc", pc, 32'h0);
        chk("self_state", 32'(state), 32'h1);
        chk_retired("self_ret", 32'd1);

        // wrap at top of address space
        next_pc = 32'hFFFF_FFFC;
        step();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        next_pc = 32'h0;
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_fault", 32'(fault), 32'h0);
        chk("wrap_state", 32'(state), 32'h1);
        chk_retired("wrap_ret", 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
